// File: rtl/ser_par_align_if.sv
// Serial-in / aligned-word-out bundle between the line front end and the deserializer.
interface ser_par_align_if #(
    parameter int unsigned WIDTH = 10
);
    logic             enable;
    logic             in;
    logic [WIDTH-1:0] out;
    logic             valid;
    logic             is_comma;
    logic             locked;

    // Line side: presents serial bits, consumes aligned words.
    modport master (
        output enable,
        output in,
        input  out,
        input  valid,
        input  is_comma,
        input  locked
    );

    // Deserializer side.
    modport slave (
        input  enable,
        input  in,
        output out,
        output valid,
        output is_comma,
        output locked
    );
endinterface

// File: rtl/ser_par_align.sv
// Receive deserializer: hunts for K28.5, qualifies alignment over several commas,
// then emits aligned 10-bit words (bit 0 = first bit received) with a valid strobe.
module ser_par_align #(
    parameter int unsigned           WIDTH    = 10,
    parameter logic [WIDTH-1:0]      COMMA_N  = 10'h17C,
    parameter logic [WIDTH-1:0]      COMMA_P  = 10'h283,
    parameter int unsigned           LOCK_CNT = 3,
    parameter int unsigned           LOSS_CNT = 4
) (
    input  logic                reloj,
    input  logic                reset,
    ser_par_align_if.slave      bus
);

    localparam int unsigned POS_W  = $clog2(WIDTH);
    localparam int unsigned ACNT_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned ECNT_W = $clog2(LOSS_CNT + 1);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]        r_state;
    logic [WIDTH-1:0]  r_sr;
    logic [POS_W-1:0]  r_pos;
    logic [ACNT_W-1:0] r_acnt;
    logic [ECNT_W-1:0] r_ecnt;
    logic [WIDTH-1:0]  r_out;
    logic              r_valid;
    logic              r_is_comma;
    logic              r_locked;

    logic [1:0]        w_nxt_state;
    logic [WIDTH-1:0]  w_nxt_sr;
    logic [POS_W-1:0]  w_nxt_pos;
    logic [ACNT_W-1:0] w_nxt_acnt;
    logic [ECNT_W-1:0] w_nxt_ecnt;
    logic [WIDTH-1:0]  w_nxt_out;
    logic              w_nxt_valid;
    logic              w_nxt_is_comma;

    logic [WIDTH-1:0]  w_window;
    logic              w_match;
    logic              w_boundary;

    // Window including the bit being sampled now; comma detect and word-boundary decode.
    always_comb begin
        w_window   = {bus.in, r_sr[WIDTH-1:1]};
        w_match    = (w_window == COMMA_N) || (w_window == COMMA_P);
        w_boundary = (r_pos == POS_W'(WIDTH - 1));
    end

    // Next-state and next-output logic; everything holds while enable is low.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_sr       = r_sr;
        w_nxt_pos      = r_pos;
        w_nxt_acnt     = r_acnt;
        w_nxt_ecnt     = r_ecnt;
        w_nxt_out      = r_out;
        w_nxt_valid    = 1'b0;
        w_nxt_is_comma = r_is_comma;

        if (bus.enable) begin
            w_nxt_sr  = w_window;
            w_nxt_pos = w_boundary ? '0 : r_pos + POS_W'(1);

            case (r_state)
                ST_HUNT: begin
                    if (w_match) begin
                        w_nxt_pos   = '0;
                        w_nxt_acnt  = ACNT_W'(1);
                        w_nxt_state = ST_SYNC;
                    end
                end

                ST_SYNC: begin
                    // Boundary decision wins over realignment on the same bit.
                    if (w_boundary) begin
                        if (w_match) begin
                            w_nxt_acnt = r_acnt + ACNT_W'(1);
                            if (r_acnt >= ACNT_W'(LOCK_CNT - 1)) begin
                                w_nxt_acnt  = ACNT_W'(LOCK_CNT);
                                w_nxt_ecnt  = '0;
                                w_nxt_state = ST_LOCKED;
                            end
                        end else begin
                            w_nxt_acnt  = '0;
                            w_nxt_state = ST_HUNT;
                        end
                    end else if (w_match) begin
                        w_nxt_pos  = '0;
                        w_nxt_acnt = ACNT_W'(1);
                    end
                end

                ST_LOCKED: begin
                    if (w_boundary) begin
                        w_nxt_out      = w_window;
                        w_nxt_valid    = 1'b1;
                        w_nxt_is_comma = w_match;
                        if (w_match) begin
                            w_nxt_ecnt = '0;
                        end
                    end else if (w_match) begin
                        // Comma seen off the current boundary counts toward loss of lock.
                        if (r_ecnt >= ECNT_W'(LOSS_CNT - 1)) begin
                            w_nxt_pos   = '0;
                            w_nxt_acnt  = '0;
                            w_nxt_ecnt  = '0;
                            w_nxt_state = ST_HUNT;
                        end else begin
                            w_nxt_ecnt = r_ecnt + ECNT_W'(1);
                        end
                    end
                end

                default: begin
                    w_nxt_pos   = '0;
                    w_nxt_acnt  = '0;
                    w_nxt_ecnt  = '0;
                    w_nxt_state = ST_HUNT;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge reloj) begin
        if (reset) begin
            r_state    <= ST_HUNT;
            r_sr       <= '0;
            r_pos      <= '0;
            r_acnt     <= '0;
            r_ecnt     <= '0;
            r_out      <= '0;
            r_valid    <= 1'b0;
            r_is_comma <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_sr       <= w_nxt_sr;
            r_pos      <= w_nxt_pos;
            r_acnt     <= w_nxt_acnt;
            r_ecnt     <= w_nxt_ecnt;
            r_out      <= w_nxt_out;
            r_valid    <= w_nxt_valid;
            r_is_comma <= w_nxt_is_comma;
            r_locked   <= (w_nxt_state == ST_LOCKED);
        end
    end

    assign bus.out      = r_out;
    assign bus.valid    = r_valid;
    assign bus.is_comma = r_is_comma;
    assign bus.locked   = r_locked;

endmodule

// File: tb/tb_ser_par_align.sv
// Bench for ser_par_align: directed scenarios with literal checks plus a randomized
// stream, all compared every cycle against a bit-history reference model.
module tb_ser_par_align;

    localparam logic [9:0] K_N = 10'h17C;
    localparam logic [9:0] K_P = 10'h283;

    logic reloj = 1'b0;
    logic reset = 1'b1;

    ser_par_align_if bus ();

    ser_par_align dut (
        .reloj (reloj),
        .reset (reset),
        .bus   (bus)
    );

    always #5 reloj = ~reloj;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Alignment is tracked as the absolute bit index where the current word starts.
    typedef enum int {M_HUNT, M_SYNC, M_LOCK} mstate_t;

    bit         hist[$];
    int         nbits;
    int         origin;
    int         hits;
    int         strays;
    mstate_t    mst;
    logic [9:0] exp_out;
    logic       exp_valid;
    logic       exp_is_comma;
    logic       exp_locked;

    function automatic void model_reset();
        hist.delete();
        nbits        = 0;
        origin       = 0;
        hits         = 0;
        strays       = 0;
        mst          = M_HUNT;
        exp_out      = '0;
        exp_valid    = 1'b0;
        exp_is_comma = 1'b0;
        exp_locked   = 1'b0;
    endfunction

    function automatic void model_step(input bit b);
        logic [9:0] win;
        bit         is_c;
        bit         at_end;
        int         k;
        int         sz;
        hist.push_back(b);
        k      = nbits;
        nbits  = nbits + 1;
        sz     = hist.size();
        win    = '0;
        for (int i = 0; i < 10; i++) begin
            if (sz - 10 + i >= 0) win[i] = hist[sz - 10 + i];
        end
        is_c      = (win == K_N) || (win == K_P);
        at_end    = ((k - origin) % 10) == 9;
        exp_valid = 1'b0;
        case (mst)
            M_HUNT: if (is_c) begin
                origin = k + 1; hits = 1; mst = M_SYNC;
            end
            M_SYNC: if (at_end) begin
                if (is_c) begin
                    hits++;
                    if (hits >= 3) begin mst = M_LOCK; strays = 0; end
                end else begin
                    hits = 0; mst = M_HUNT;
                end
            end else if (is_c) begin
                origin = k + 1; hits = 1;
            end
            M_LOCK: if (at_end) begin
                exp_out = win; exp_valid = 1'b1; exp_is_comma = is_c;
                if (is_c) strays = 0;
            end else if (is_c) begin
                strays++;
                if (strays >= 4) begin
                    mst = M_HUNT; origin = k + 1; hits = 0; strays = 0;
                end
            end
            default: mst = M_HUNT;
        endcase
        exp_locked = (mst == M_LOCK);
    endfunction

    initial model_reset();

    // Model advances on the same edge the DUT samples.
    always @(posedge reloj) begin
        if (reset)           model_reset();
        else if (bus.enable) model_step(bus.in);
        else                 exp_valid = 1'b0;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge reloj) begin
        if (chk_on) begin
            check("valid",  32'(bus.valid),  32'(exp_valid));
            check("locked", 32'(bus.locked), 32'(exp_locked));
            if (exp_valid) begin
                check("out",      32'(bus.out),      32'(exp_out));
                check("is_comma", 32'(bus.is_comma), 32'(exp_is_comma));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_bit(input bit b);
        @(negedge reloj);
        reset      = 1'b0;
        bus.enable = 1'b1;
        bus.in     = b;
        @(posedge reloj);
        #1;
    endtask

    task automatic idle();
        @(negedge reloj);
        reset      = 1'b0;
        bus.enable = 1'b0;
        bus.in     = 1'($urandom);
        @(posedge reloj);
        #1;
    endtask

    task automatic reset_cycle(input bit en);
        @(negedge reloj);
        reset      = 1'b1;
        bus.enable = en;
        bus.in     = 1'($urandom);
        @(posedge reloj);
        #1;
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) send_bit(w[i]);
    endtask

    // Random-phase bit: occasionally stalls with enable low first.
    task automatic send_bit_r(input bit b);
        while ($urandom_range(0, 99) < 20) idle();
        send_bit(b);
    endtask

    task automatic send_word_r(input logic [9:0] w);
        for (int i = 0; i < 10; i++) send_bit_r(w[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, time %0t", $time);
        $fatal(1);
    end

    initial begin
        bus.enable = 1'b0;
        bus.in     = 1'b0;

        // Reset held for 3 cycles with random bits and enable high.
        for (int i = 0; i < 3; i++) begin
            reset_cycle(1'b1);
            chk_on = 1'b1;
            check("rst_out",    32'(bus.out),    32'h0);
            check("rst_valid",  32'(bus.valid),  32'h0);
            check("rst_locked", 32'(bus.locked), 32'h0);
        end

        // Lock acquisition.
        for (int i = 0; i < 7; i++) send_bit(1'($urandom));
        send_word(K_N);
        send_word(K_N);
        check("lock_after_2", 32'(bus.locked), 32'h0);
        send_word(K_N);
        check("lock_after_3",       32'(bus.locked), 32'h1);
        check("model_lock_after_3", 32'(exp_locked), 32'h1);
        send_word(10'h0AA);
        check("first_valid",     32'(bus.valid),    32'h1);
        check("first_out",       32'(bus.out),      32'h0AA);
        check("first_is_comma",  32'(bus.is_comma), 32'h0);
        check("model_first_out", 32'(exp_out),      32'h0AA);

        // Comma flagging while locked.
        for (int i = 0; i < 2; i++) begin
            send_word(K_P);
            check("alt_out_k",   32'(bus.out),      32'h283);
            check("alt_flag_k",  32'(bus.is_comma), 32'h1);
            send_word(10'h155);
            check("alt_out_d",   32'(bus.out),      32'h155);
            check("alt_flag_d",  32'(bus.is_comma), 32'h0);
        end

        // Enable gating mid-word.
        begin
            logic [9:0] gw;
            gw = 10'h0F0;
            for (int i = 0; i < 4; i++) send_bit(gw[i]);
            for (int i = 0; i < 5; i++) begin
                idle();
                check("gate_no_valid", 32'(bus.valid), 32'h0);
            end
            for (int i = 4; i < 10; i++) send_bit(gw[i]);
            check("gate_valid", 32'(bus.valid), 32'h1);
            check("gate_out",   32'(bus.out),   32'h0F0);
        end

        // Loss of lock after a 3-bit slip, then relock.
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        for (int i = 0; i < 3; i++) begin
            send_word(K_N);
            check("slip_still_locked", 32'(bus.locked), 32'h1);
        end
        send_word(K_N);
        check("slip_lost",       32'(bus.locked), 32'h0);
        check("slip_valid_low",  32'(bus.valid),  32'h0);
        check("model_slip_lost", 32'(exp_locked), 32'h0);
        send_word(K_N);
        send_word(K_N);
        check("relock_pending", 32'(bus.locked), 32'h0);
        send_word(K_N);
        check("relock", 32'(bus.locked), 32'h1);

        // SYNC failure returns to HUNT.
        reset_cycle(1'b0);
        send_word(K_N);
        check("sync_fail_1", 32'(bus.locked), 32'h0);
        send_word(10'h3FF);
        check("sync_fail_2", 32'(bus.locked), 32'h0);
        send_word(K_N);
        send_word(K_N);
        check("sync_restart", 32'(bus.locked), 32'h0);
        send_word(K_N);
        check("sync_relock", 32'(bus.locked), 32'h1);

        // Randomized stream: commas, data, bit slips, stalls and occasional resets.
        for (int n = 0; n < 350; n++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 30) begin
                send_word_r(($urandom_range(0, 1) != 0) ? K_P : K_N);
            end else if (sel < 36) begin
                for (int i = 0; i < int'($urandom_range(1, 9)); i++) send_bit_r(1'($urandom));
            end else if (sel < 38) begin
                reset_cycle(1'($urandom));
            end else begin
                send_word_r(10'($urandom));
            end
        end

        idle();
        idle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ser_par_align.md
Name: ser_par_align

Overview:
- Receive-side deserializer for the 10-bit serial link. The transmitter sends bit 0 of each word first, one bit per enabled clock.
- The block recovers word boundaries by hunting for the K28.5 comma, qualifies alignment over several commas, and then emits aligned 10-bit words with a valid strobe.
- Sits between the serial line input and the downstream 8b/10b decoder.

Parameters:
- WIDTH, 10, symbol width in bits; only 10 is supported.
- COMMA_N, 10'h17C, K28.5 RD- pattern in LSB-first word order.
- COMMA_P, 10'h283, K28.5 RD+ pattern in LSB-first word order.
- LOCK_CNT, 3, number of consecutive aligned commas required to enter LOCKED.
- LOSS_CNT, 4, number of consecutive misaligned commas that drops LOCKED back to HUNT.

Ports:
- reloj  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  bit-valid qualifier; in is sampled only when enable=1.
- in  in  1  serial data bit.
- out  out  10  aligned parallel word; bit 0 = first bit received.
- valid  out  1  one-cycle strobe: out holds a new word.
- is_comma  out  1  qualifies out: the word is COMMA_N or COMMA_P; meaningful only when valid=1.
- locked  out  1  high while in state LOCKED.

Behaviour:
- Window: w = {in, sr[9:0] >> 1} (new bit enters at MSB); sr <= w on every enable=1 edge. match = (w==COMMA_N)||(w==COMMA_P).
- pos: 4-bit counter, 0..9, counting bits of the current word. On enable it increments and wraps 9->0. Word boundary: enable && pos==9.
- enable=0: sr, pos, state and counters hold; valid=0.
- Reset (synchronous, also mid-word): sr=0, pos=0, state=HUNT, acnt=0, ecnt=0, out=0, valid=0, is_comma=0, locked=0.
- State HUNT:
  - On enable && match: pos<=0, acnt<=1, go to SYNC.
  - Otherwise pos is free-running and ignored.
  - valid stays 0.
- State SYNC:
  - Boundary with match: acnt++. If acnt+1==LOCK_CNT, go to LOCKED with ecnt<=0.
  - Boundary without match: go to HUNT, acnt<=0.
  - Non-boundary match (realignment): pos<=0, acnt<=1, stay in SYNC.
  - valid stays 0.
- State LOCKED:
  - Every boundary: out<=w, valid<=1, is_comma<=match.
  - Boundary with match: ecnt<=0.
  - Non-boundary match: ecnt++. If ecnt+1==LOSS_CNT, go to HUNT with pos<=0, acnt<=0, ecnt<=0, and emit no further words.
  - Non-comma data never causes loss of lock.
- Latency: out/valid update on the same edge that samples the 10th bit of a word, i.e. registered one edge after that bit is presented on in.
- valid is high for exactly one cycle per word and is never high in consecutive cycles unless enable is continuously 1 and the word is... never: at least 10 enables separate strobes.
- locked is a registered decode of state==LOCKED and changes on the same edge as the state transition.
- Simultaneous events:
  - A boundary match takes precedence over any realign logic.
  - Reset overrides enable.
- Counters saturate: acnt never exceeds LOCK_CNT; ecnt never exceeds LOSS_CNT.

Test Plan:
- Reset: hold reset for 3 cycles while driving random bits with enable=1. Require out=0, valid=0, locked=0 throughout; after release, state=HUNT.
- Lock acquisition: send 7 random bits, then 3x 10'h17C LSB-first, then 10'h0AA. Require locked to rise on the edge sampling the last bit of comma #3, and the first valid to carry out=10'h0AA with is_comma=0.
- Comma flagging in LOCKED: send alternating 10'h283 and 10'h155. Require valid every 10 enabled bits, with out/is_comma alternating 283/1 and 155/0.
- Enable gating: while LOCKED, deassert enable for 5 cycles mid-word. Require no valid pulse, and the word completes correctly once enable returns.
- Loss of lock: while LOCKED, shift the stream by 3 bits and send 4 commas. Require locked to fall on the 4th misaligned comma and valid to stay 0. Then send 3 aligned commas and require relock.
- SYNC failure: send 1 comma followed by 10'h3FF. Require return to HUNT with locked never asserted.
